// File: rtl/intr_pkg.sv
// Shared interrupt definitions: controller state encoding, handler base address
// and the Cause codes used by the exception datapath.
package intr_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Also the control unit's Ibase, so both sides agree on the handler table.
    localparam logic [31:0] VEC_BASE_DEFAULT = 32'h54;

    localparam logic [4:0] CAUSE_EXT_INT  = 5'd0;
    localparam logic [4:0] CAUSE_OVERFLOW = 5'd4;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder; valid is low when no request bit is set.
module prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    output logic [ID_W-1:0] id,
    output logic            valid
);

    // Scanning from the top down lets the lowest set index overwrite the others.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = ID_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intr_controller.sv
// Prioritised interrupt controller: latches request edges, masks them, raises Intr
// for the best eligible source and tracks it through acknowledge and eret.
module intr_controller
    import intr_pkg::*;
#(
    parameter int          N               = 4,
    parameter int          ID_W            = 2,
    parameter logic [N-1:0] MASK_RST       = {N{1'b1}},
    parameter logic [31:0] VEC_BASE        = VEC_BASE_DEFAULT,
    parameter int          VEC_STRIDE_LOG2 = 4
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [N-1:0]    Irq,
    input  logic            Wmask,
    input  logic [N-1:0]    MaskIn,
    input  logic            Inta,
    input  logic            Eret,
    output logic            Intr,
    output logic [ID_W-1:0] IrqId,
    output logic [31:0]     IrqVec,
    output logic [N-1:0]    Pending,
    output logic [N-1:0]    Mask,
    output logic            Busy,
    output logic [1:0]      dbg_state
);

    // Handshake: Intr is held high from REQ entry until the edge that samples
    // Inta high; Inta is only honoured in REQ and Eret only in SERVICE.

    logic [1:0]      state;
    logic [N-1:0]    irq_q;
    logic [N-1:0]    rise;
    logic [N-1:0]    eligible;
    logic [N-1:0]    pend_clr;
    logic [N-1:0]    pending_next;
    logic [ID_W-1:0] sel_id;
    logic            sel_valid;

    assign rise     = Irq & ~irq_q;
    assign eligible = Pending & Mask;

    prio_enc #(
        .N    (N),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req   (eligible),
        .id    (sel_id),
        .valid (sel_valid)
    );

    // A new edge on the bit being acknowledged wins over the clear.
    always_comb begin
        pend_clr = '0;
        if (state == ST_REQ && Inta) begin
            pend_clr[IrqId] = 1'b1;
        end
        pending_next = (Pending & ~pend_clr) | rise;
    end

    // irq_q keeps tracking Irq through reset, so a line already high at release
    // is not seen as an edge.
    always_ff @(posedge Clk) begin
        irq_q <= Irq;
        if (Reset) begin
            state   <= ST_IDLE;
            Intr    <= 1'b0;
            IrqId   <= '0;
            Pending <= '0;
            Mask    <= MASK_RST;
        end else begin
            Pending <= pending_next;
            if (Wmask) begin
                Mask <= MaskIn;
            end
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        IrqId <= sel_id;
                        Intr  <= 1'b1;
                        state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (Inta) begin
                        Intr  <= 1'b0;
                        state <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (Eret) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    Intr  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign IrqVec    = VEC_BASE + (32'(IrqId) << VEC_STRIDE_LOG2);
    assign Busy      = (state != ST_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_intr_controller.sv
// Bench for intr_controller: directed vector table, corner-case sequences and a
// randomized run against a behavioural model of the interrupt rules.
module tb_intr_controller;

    logic        Clk;
    logic        Reset;
    logic [3:0]  Irq;
    logic        Wmask;
    logic [3:0]  MaskIn;
    logic        Inta;
    logic        Eret;
    logic        Intr;
    logic [1:0]  IrqId;
    logic [31:0] IrqVec;
    logic [3:0]  Pending;
    logic [3:0]  Mask;
    logic        Busy;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    intr_controller dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Irq       (Irq),
        .Wmask     (Wmask),
        .MaskIn    (MaskIn),
        .Inta      (Inta),
        .Eret      (Eret),
        .Intr      (Intr),
        .IrqId     (IrqId),
        .IrqVec    (IrqVec),
        .Pending   (Pending),
        .Mask      (Mask),
        .Busy      (Busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        Irq = 4'h0; Wmask = 1'b0; MaskIn = 4'h0; Inta = 1'b0; Eret = 1'b0;
    endtask

    task automatic check_reset_vals(input int idx);
        check("rst_intr", idx, 64'(Intr), 64'd0);
        check("rst_id", idx, 64'(IrqId), 64'd0);
        check("rst_vec", idx, 64'(IrqVec), 64'h54);
        check("rst_pend", idx, 64'(Pending), 64'd0);
        check("rst_mask", idx, 64'(Mask), 64'hF);
        check("rst_busy", idx, 64'(Busy), 64'd0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] irq;
        logic       wmask;
        logic [3:0] maskin;
        logic       inta;
        logic       eret;
        logic       rst;
        logic       e_intr;
        logic [1:0] e_id;
        logic [3:0] e_pend;
        logic [3:0] e_mask;
        logic       e_busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] irq, input logic wm, input logic [3:0] mi,
                       input logic inta, input logic eret, input logic rst,
                       input logic e_intr, input logic [1:0] e_id, input logic [3:0] e_pend,
                       input logic [3:0] e_mask, input logic e_busy);
        vec_t v;
        v.irq = irq; v.wmask = wm; v.maskin = mi; v.inta = inta; v.eret = eret; v.rst = rst;
        v.e_intr = e_intr; v.e_id = e_id; v.e_pend = e_pend; v.e_mask = e_mask;
        v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_pend[4];
    bit m_mask[4];
    bit m_prev[4];
    bit m_req_out;
    bit m_in_svc;
    int m_id;
    logic [43:0] exp_q[$];

    function automatic logic [43:0] model_outputs();
        logic [3:0]  p;
        logic [3:0]  m;
        logic [31:0] vec;
        for (int i = 0; i < 4; i++) begin
            p[i] = m_pend[i];
            m[i] = m_mask[i];
        end
        vec = 32'h54 + 32'(m_id) * 32'd16;
        return {m_req_out, 2'(m_id), vec, p, m, (m_req_out || m_in_svc)};
    endfunction

    function automatic void model_step(input logic [3:0] irq, input logic wm,
                                       input logic [3:0] mi, input logic inta,
                                       input logic eret, input logic rst);
        bit rise[4];
        bit found;
        for (int i = 0; i < 4; i++) begin
            rise[i]   = irq[i] && !m_prev[i];
            m_prev[i] = irq[i];
        end
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 1'b0;
                m_mask[i] = 1'b1;
            end
            m_req_out = 1'b0;
            m_in_svc  = 1'b0;
            m_id      = 0;
            return;
        end
        if (m_req_out) begin
            if (inta) begin
                m_pend[m_id] = 1'b0;
                m_req_out    = 1'b0;
                m_in_svc     = 1'b1;
            end
        end else if (m_in_svc) begin
            if (eret) m_in_svc = 1'b0;
        end else begin
            found = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!found && m_pend[i] && m_mask[i]) begin
                    found     = 1'b1;
                    m_id      = i;
                    m_req_out = 1'b1;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (rise[i]) m_pend[i] = 1'b1;
            if (wm) m_mask[i] = mi[i];
        end
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [3:0]  r_irq;
        logic [43:0] exp;
        logic [43:0] act;
        int          rises;
        int          pend_sets;
        logic        prev_intr;
        logic        prev_p0;

        Reset = 1'b1;
        drive_idle();

        // irq wm mi inta eret rst | intr id pend mask busy
        add(4'h0, 0, 4'h0, 0, 0, 1,  0, 2'd0, 4'h0, 4'hF, 0);
        add(4'h0, 0, 4'h0, 0, 0, 1,  0, 2'd0, 4'h0, 4'hF, 0);
        add(4'h4, 0, 4'h0, 0, 0, 0,  0, 2'd0, 4'h4, 4'hF, 0);
        add(4'h4, 0, 4'h0, 0, 0, 0,  1, 2'd2, 4'h4, 4'hF, 1);
        add(4'h4, 0, 4'h0, 1, 0, 0,  0, 2'd2, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 1, 0,  0, 2'd2, 4'h0, 4'hF, 0);
        add(4'hA, 0, 4'h0, 0, 0, 0,  0, 2'd2, 4'hA, 4'hF, 0);
        add(4'hA, 0, 4'h0, 0, 0, 0,  1, 2'd1, 4'hA, 4'hF, 1);
        add(4'hA, 0, 4'h0, 1, 0, 0,  0, 2'd1, 4'h8, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 1, 0,  0, 2'd1, 4'h8, 4'hF, 0);
        add(4'h0, 0, 4'h0, 0, 0, 0,  1, 2'd3, 4'h8, 4'hF, 1);
        add(4'h0, 0, 4'h0, 1, 0, 0,  0, 2'd3, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 1, 0,  0, 2'd3, 4'h0, 4'hF, 0);
        add(4'h0, 1, 4'hE, 0, 0, 0,  0, 2'd3, 4'h0, 4'hE, 0);
        add(4'h1, 0, 4'h0, 0, 0, 0,  0, 2'd3, 4'h1, 4'hE, 0);
        add(4'h1, 0, 4'h0, 0, 0, 0,  0, 2'd3, 4'h1, 4'hE, 0);
        add(4'h1, 1, 4'hF, 0, 0, 0,  0, 2'd3, 4'h1, 4'hF, 0);
        add(4'h1, 0, 4'h0, 0, 0, 0,  1, 2'd0, 4'h1, 4'hF, 1);
        add(4'h1, 0, 4'h0, 1, 0, 0,  0, 2'd0, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 1, 0,  0, 2'd0, 4'h0, 4'hF, 0);
        add(4'h2, 0, 4'h0, 0, 0, 0,  0, 2'd0, 4'h2, 4'hF, 0);
        add(4'h2, 0, 4'h0, 0, 0, 0,  1, 2'd1, 4'h2, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 0, 0,  1, 2'd1, 4'h2, 4'hF, 1);
        add(4'h2, 0, 4'h0, 1, 0, 0,  0, 2'd1, 4'h2, 4'hF, 1);
        add(4'h2, 0, 4'h0, 0, 1, 0,  0, 2'd1, 4'h2, 4'hF, 0);
        add(4'h2, 0, 4'h0, 0, 0, 0,  1, 2'd1, 4'h2, 4'hF, 1);
        add(4'h2, 0, 4'h0, 1, 0, 0,  0, 2'd1, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 1, 0,  0, 2'd1, 4'h0, 4'hF, 0);
        add(4'h0, 0, 4'h0, 1, 1, 0,  0, 2'd1, 4'h0, 4'hF, 0);
        add(4'h1, 0, 4'h0, 0, 0, 0,  0, 2'd1, 4'h1, 4'hF, 0);
        add(4'h1, 0, 4'h0, 0, 0, 0,  1, 2'd0, 4'h1, 4'hF, 1);
        add(4'h1, 0, 4'h0, 0, 1, 0,  1, 2'd0, 4'h1, 4'hF, 1);
        add(4'h1, 0, 4'h0, 1, 0, 0,  0, 2'd0, 4'h0, 4'hF, 1);
        add(4'h1, 0, 4'h0, 1, 0, 0,  0, 2'd0, 4'h0, 4'hF, 1);
        add(4'h0, 0, 4'h0, 0, 1, 0,  0, 2'd0, 4'h0, 4'hF, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            Irq = tbl[i].irq; Wmask = tbl[i].wmask; MaskIn = tbl[i].maskin;
            Inta = tbl[i].inta; Eret = tbl[i].eret; Reset = tbl[i].rst;
            step();
            check("tbl_intr", i, 64'(Intr), 64'(tbl[i].e_intr));
            check("tbl_id", i, 64'(IrqId), 64'(tbl[i].e_id));
            check("tbl_vec", i, 64'(IrqVec), 64'(32'h54 + 32'(tbl[i].e_id) * 32'd16));
            check("tbl_pend", i, 64'(Pending), 64'(tbl[i].e_pend));
            check("tbl_mask", i, 64'(Mask), 64'(tbl[i].e_mask));
            check("tbl_busy", i, 64'(Busy), 64'(tbl[i].e_busy));
            if (i == 0) check("tbl_state_idle", i, 64'(dbg_state), 64'd0);
        end
        drive_idle();
        Reset = 1'b0;

        // Level held high for 20 cycles: one pend, one request.
        rises = 0; pend_sets = 0;
        prev_intr = Intr; prev_p0 = Pending[0];
        for (int i = 0; i < 20; i++) begin
            Irq  = 4'h1;
            Inta = Intr;
            step();
            if (Intr && !prev_intr) rises++;
            if (Pending[0] && !prev_p0) pend_sets++;
            prev_intr = Intr; prev_p0 = Pending[0];
        end
        Inta = 1'b0;
        check("level_req_count", 0, 64'(rises), 64'd1);
        check("level_pend_count", 0, 64'(pend_sets), 64'd1);
        Eret = 1'b1;
        step();
        Eret = 1'b0;
        check("level_busy", 0, 64'(Busy), 64'd0);
        check("level_pend", 0, 64'(Pending), 64'd0);
        step();
        check("level_no_rereq", 0, 64'(Intr), 64'd0);
        Irq = 4'h0;
        step();

        // Line high across reset release is not an edge.
        Reset = 1'b1; Irq = 4'h1;
        step();
        step();
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("rst_hold_pend", 0, 64'(Pending), 64'd0);
        check("rst_hold_intr", 0, 64'(Intr), 64'd0);
        check("rst_hold_busy", 0, 64'(Busy), 64'd0);
        Irq = 4'h0;
        step();

        // Reset while in REQ.
        Wmask = 1'b1; MaskIn = 4'hD;
        step();
        Wmask = 1'b0;
        Irq = 4'h4;
        step();
        step();
        check("mid_req_intr", 0, 64'(Intr), 64'd1);
        check("mid_req_mask", 0, 64'(Mask), 64'hD);
        Reset = 1'b1;
        step();
        check_reset_vals(0);
        Reset = 1'b0; Irq = 4'h0;
        step();

        // Reset while in SERVICE.
        Irq = 4'h4;
        step();
        step();
        Inta = 1'b1;
        step();
        Inta = 1'b0;
        check("mid_svc_busy", 0, 64'(Busy), 64'd1);
        check("mid_svc_intr", 0, 64'(Intr), 64'd0);
        Reset = 1'b1;
        step();
        check_reset_vals(1);
        Reset = 1'b0; Irq = 4'h0;
        step();

        // Randomized run against the model.
        drive_idle();
        Reset = 1'b1;
        model_step(Irq, Wmask, MaskIn, Inta, Eret, Reset);
        step();
        Reset = 1'b0;
        r_irq = 4'h0;
        for (int c = 0; c < 3000; c++) begin
            r_irq  = r_irq ^ (4'($urandom) & 4'($urandom));
            Irq    = r_irq;
            Wmask  = ($urandom_range(0, 15) == 0);
            MaskIn = 4'($urandom);
            Inta   = Intr ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
            Eret   = ($urandom_range(0, 3) == 0);
            Reset  = ($urandom_range(0, 199) == 0);
            model_step(Irq, Wmask, MaskIn, Inta, Eret, Reset);
            exp_q.push_back(model_outputs());
            step();
            exp = exp_q.pop_front();
            act = {Intr, IrqId, IrqVec, Pending, Mask, Busy};
            check("rand_outputs", c, 64'(act), 64'(exp));
        end
        drive_idle();
        Reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
